// File: rtl/io_bidir_exerciser.sv
// rtl/io_bidir_exerciser.sv - PRBS loopback driver/checker for a bidirectional pad, then pull-level check.
// Optional pull check in PCHK is enabled by defining IO_EXER_PULL_CHECK_EN.
module io_bidir_exerciser #(
   parameter int unsigned PATTERN_LEN = 16,
   parameter int unsigned LOOP_LAT    = 2,
   parameter int unsigned TURN_CYCLES = 4,
   parameter logic [6:0]  SEED        = 7'h01,
   parameter logic        PULL_VAL    = 1'b1,
   parameter int unsigned ERR_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             pad_o,
   output logic             pad_t,
   input  logic             pad_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_DRIVE, S_DRAIN, S_TURN, S_PCHK, S_DONE
   } state_t;

   localparam logic [6:0]       SEED_C    = (SEED == 7'h00) ? 7'h01 : SEED;
   localparam logic [7:0]       LEN_LAST  = 8'(PATTERN_LEN - 1);
   localparam logic [7:0]       LAT_LAST  = 8'(LOOP_LAT - 1);
   localparam logic [7:0]       TURN_LAST = 8'(TURN_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [6:0]          lfsr_q, lfsr_d;
   logic [ERR_W-1:0]    err_q, err_d;
   logic                pass_q, pass_d;
   logic                pad_t_q, pad_t_d;
   logic                pad_o_q, pad_o_d;
   logic [LOOP_LAT-1:0] exp_q, vld_q;
   logic                flush;
   logic                cmp_hit;

   function automatic logic [6:0] lfsr_next(input logic [6:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction

   assign cmp_hit = vld_q[LOOP_LAT-1] && (pad_i != exp_q[LOOP_LAT-1]);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lfsr_d  = lfsr_q;
      err_d   = err_q;
      pass_d  = pass_q;
      pad_t_d = 1'b1;
      pad_o_d = 1'b0;
      flush   = 1'b0;
      if (cmp_hit && err_q != ERR_MAX) err_d = err_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_DRIVE;
               cnt_d   = 8'd0;
               lfsr_d  = SEED_C;
               err_d   = '0;
               pass_d  = 1'b0;
               pad_t_d = 1'b0;
               pad_o_d = SEED_C[0];
            end
         end
         S_DRIVE: begin
            pad_t_d = 1'b0;
            lfsr_d  = lfsr_next(lfsr_q);
            if (cnt_q == LEN_LAST) begin
               state_d = S_DRAIN;
               cnt_d   = 8'd0;
               pad_o_d = pad_o_q;
            end else begin
               cnt_d   = cnt_q + 8'd1;
               pad_o_d = lfsr_d[0];
            end
         end
         S_DRAIN: begin
            // Last driven bit stays on the pad until its compare has landed.
            if (cnt_q == LAT_LAST) begin
               state_d = S_TURN;
               cnt_d   = 8'd0;
            end else begin
               cnt_d   = cnt_q + 8'd1;
               pad_t_d = 1'b0;
               pad_o_d = pad_o_q;
            end
         end
         S_TURN: begin
            if (cnt_q == TURN_LAST) begin
               cnt_d = 8'd0;
`ifdef IO_EXER_PULL_CHECK_EN
               state_d = S_PCHK;
`else
               state_d = S_DONE;
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_PCHK: begin
            if (pad_i != PULL_VAL && err_q != ERR_MAX) err_d = err_q + 1'b1;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_DONE && state_q != S_DONE) pass_d = (err_d == '0);
      // Abort overrides everything while busy; the error count is kept for inspection.
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         cnt_d   = 8'd0;
         pad_t_d = 1'b1;
         pad_o_d = 1'b0;
         pass_d  = 1'b0;
         err_d   = err_q;
         flush   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         lfsr_q  <= SEED_C;
         err_q   <= '0;
         pass_q  <= 1'b0;
         pad_t_q <= 1'b1;
         pad_o_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         err_q   <= err_d;
         pass_q  <= pass_d;
         pad_t_q <= pad_t_d;
         pad_o_q <= pad_o_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q <= '0;
         vld_q <= '0;
      end else begin
         exp_q[0] <= pad_o_q;
         for (int i = 1; i < LOOP_LAT; i++) exp_q[i] <= exp_q[i-1];
         if (flush) begin
            vld_q <= '0;
         end else begin
            vld_q[0] <= (state_q == S_DRIVE);
            for (int i = 1; i < LOOP_LAT; i++) vld_q[i] <= vld_q[i-1];
         end
      end
   end

   assign pad_o     = pad_o_q;
   assign pad_t     = pad_t_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign pass      = pass_q;
   assign err_count = err_q;

endmodule
